uriscv_alu_arb: RTL and testbench
=================================

# uriscv_alu_arb

Two-port arbiter and sequencer that shares one combinational uriscv ALU between two requesters. Typical requesters are the core execute path (port 0) and a secondary agent such as a debug or coprocessor unit (port 1). Each accepted request is registered into a single issue stage, evaluated by the external ALU, and captured into a per-port response register. That register holds the result until the requester drains it. Operation codes pass through unchanged using the RV_ALU_* encodings; the block does not decode them.

## Interface
- PORT0_PRIORITY, 0: 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- req0_valid_i  in  1  port 0 request valid.
- req0_ready_o  out  1  port 0 request accepted this cycle when high together with req0_valid_i.
- req0_op_i  in  4  port 0 ALU operation (RV_ALU_*).
- req0_a_i / req0_b_i  in  32  port 0 operands.
- resp0_valid_o  out  1  port 0 result valid.
- resp0_ready_i  in  1  port 0 consumer takes the result.
- resp0_result_o  out  32  port 0 result.
- req1_* / resp1_*: same set as port 0, for port 1.
- alu_op_o  out  4  operation driven to the shared ALU.
- alu_a_o / alu_b_o  out  32  operands driven to the shared ALU.
- alu_result_i  in  32  combinational ALU result for alu_op_o/alu_a_o/alu_b_o.
- busy_o  out  1  high while the issue stage or any response register is valid.

## Operation
- Issue stage (S1) registers: s1_valid, s1_port, s1_op, s1_a, s1_b.
  - alu_op_o, alu_a_o and alu_b_o are driven directly from these registers.
- Port k eligible = !(s1_valid && s1_port==k) && (!respk_valid_o || respk_ready_i). At most one op per port is in flight.
- Grant among valid, eligible ports:
  - Exactly one candidate: that port wins.
  - Both candidates, PORT0_PRIORITY=1: port 0 wins.
  - Both candidates, PORT0_PRIORITY=0: the port not equal to last_grant wins.
- reqk_ready_o = eligible_k && !(other port valid, eligible and winning).
  - Ready depends combinationally on respk_ready_i and on the other port's valid.
  - Ready never depends on the port's own reqk_valid_i.
- Accept (reqk_valid_i && reqk_ready_o):
  - S1 loads {1, k, op, a, b}.
  - last_grant <= k. last_grant changes only on an accept.
- No accept in a cycle: s1_valid <= 0. s1_op/s1_a/s1_b hold their last values.
- S1 valid at an edge: resp{s1_port} result <= alu_result_i and its valid <= 1. The eligibility rule guarantees that slot is empty or draining.
- Response drain: respk_valid_o && respk_ready_i clears valid. A simultaneous S1 write to the same port is impossible by eligibility.
- busy_o = s1_valid | resp0_valid_o | resp1_valid_o.

## Timing
- Reset (rst_ni low, asynchronous) values:
  - s1_valid=0, s1_port=0, s1_op=0, s1_a=0, s1_b=0.
  - alu_*_o=0.
  - resp0/1_valid_o=0, resp0/1_result_o=0.
  - req0/1_ready_o follow the eligibility rule (both ports eligible).
  - busy_o=0.
  - last_grant=1, so port 0 wins the first round-robin tie.
- Reset mid-operation discards the in-flight op and any held results. Nothing is replayed.
- Latency: accept at edge N -> S1 valid during cycle N..N+1 -> respk_valid_o high after edge N+1. That is 2 cycles from accept to result.
- Throughput:
  - Aggregate: 1 op/cycle when the ports alternate.
  - Single port: 1 op per 2 cycles, with the response drained on the cycle it appears.
- Response held stable, value and valid, until taken. A port with an undrained response stays not-ready; the other port proceeds.

## Test plan
- Port 0 alone, RV_ALU_ADD a=0x00000005 b=0x00000003, resp0_ready_i=1 -> resp0_valid_o high 2 cycles after accept, resp0_result_o=0x00000008, busy_o low the cycle after drain.
- Both ports valid every cycle, PORT0_PRIORITY=0:
  - port 0 SUB 10-4, port 1 XOR 0xF0F0F0F0^0xFFFFFFFF;
  - grants alternate 0,1,0,1 starting with port 0;
  - results 0x00000006 and 0x0F0F0F0F;
  - one accept per cycle.
- PORT0_PRIORITY=1, port 0 streaming with resp0_ready_i=1 -> port 1 granted only on cycles where port 0 is ineligible (its op in S1). No port 1 starvation beyond 1 cycle.
- Backpressure: port 1 SLT signed a=0xFFFFFFFF b=1, resp1_ready_i=0 for 5 cycles:
  - resp1_result_o=0x00000001 is held stable;
  - req1_ready_o stays low;
  - port 0 ops continue to complete;
  - after release, port 1 is re-accepted in the same cycle it drains.
- Reset asserted while S1 and resp0 are valid -> all valids drop immediately (asynchronously), results=0, and the first tie after release goes to port 0.
- Shift pass-through: port 1 RV_ALU_SHIFTR_ARITH a=0x80000000 b=4 -> alu_op_o/alu_a_o/alu_b_o match for one cycle, resp1_result_o=0xF8000000.

Source files
------------

// File: rtl/uriscv_alu_arb.sv
// Two-port arbiter that time-shares one combinational uriscv ALU through a single issue stage,
// capturing each result into a per-port response register held until the requester drains it.
module uriscv_alu_arb #(
   parameter bit PORT0_PRIORITY = 1'b0,
   parameter int DATA_W         = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,

   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [3:0]        req0_op_i,
   input  logic [DATA_W-1:0] req0_a_i,
   input  logic [DATA_W-1:0] req0_b_i,
   output logic              resp0_valid_o,
   input  logic              resp0_ready_i,
   output logic [DATA_W-1:0] resp0_result_o,

   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [3:0]        req1_op_i,
   input  logic [DATA_W-1:0] req1_a_i,
   input  logic [DATA_W-1:0] req1_b_i,
   output logic              resp1_valid_o,
   input  logic              resp1_ready_i,
   output logic [DATA_W-1:0] resp1_result_o,

   output logic [3:0]        alu_op_o,
   output logic [DATA_W-1:0] alu_a_o,
   output logic [DATA_W-1:0] alu_b_o,
   input  logic [DATA_W-1:0] alu_result_i,

   output logic              busy_o
);

   logic              s1_valid_q, s1_valid_d;
   logic              s1_port_q, s1_port_d;
   logic [3:0]        s1_op_q, s1_op_d;
   logic [DATA_W-1:0] s1_a_q, s1_a_d;
   logic [DATA_W-1:0] s1_b_q, s1_b_d;

   logic              resp0_valid_q, resp0_valid_d;
   logic [DATA_W-1:0] resp0_result_q, resp0_result_d;
   logic              resp1_valid_q, resp1_valid_d;
   logic [DATA_W-1:0] resp1_result_q, resp1_result_d;

   logic              last_grant_q, last_grant_d;

   logic              elig0, elig1;
   logic              cand0, cand1;
   logic              pref1;
   logic              rdy0, rdy1;
   logic              acc0, acc1;

   // Arbitration: a port is blocked only by its own op in S1 or an undrained response.
   // Ready is built from the other port's candidacy so it never loops through its own valid.
   always_comb begin
      elig0 = !(s1_valid_q && !s1_port_q) && (!resp0_valid_q || resp0_ready_i);
      elig1 = !(s1_valid_q &&  s1_port_q) && (!resp1_valid_q || resp1_ready_i);
      cand0 = req0_valid_i && elig0;
      cand1 = req1_valid_i && elig1;
      pref1 = !PORT0_PRIORITY && !last_grant_q;
      rdy0  = elig0 && !(cand1 &&  pref1);
      rdy1  = elig1 && !(cand0 && !pref1);
      acc0  = req0_valid_i && rdy0;
      acc1  = req1_valid_i && rdy1;
   end

   // Issue stage next state: operands hold when nothing is accepted.
   always_comb begin
      s1_valid_d   = acc0 | acc1;
      s1_port_d    = s1_port_q;
      s1_op_d      = s1_op_q;
      s1_a_d       = s1_a_q;
      s1_b_d       = s1_b_q;
      last_grant_d = last_grant_q;
      if (acc0) begin
         s1_port_d    = 1'b0;
         s1_op_d      = req0_op_i;
         s1_a_d       = req0_a_i;
         s1_b_d       = req0_b_i;
         last_grant_d = 1'b0;
      end else if (acc1) begin
         s1_port_d    = 1'b1;
         s1_op_d      = req1_op_i;
         s1_a_d       = req1_a_i;
         s1_b_d       = req1_b_i;
         last_grant_d = 1'b1;
      end
   end

   // Response stage next state: drain first, then capture; eligibility keeps them exclusive.
   always_comb begin
      resp0_valid_d  = resp0_valid_q;
      resp0_result_d = resp0_result_q;
      resp1_valid_d  = resp1_valid_q;
      resp1_result_d = resp1_result_q;
      if (resp0_valid_q && resp0_ready_i) resp0_valid_d = 1'b0;
      if (resp1_valid_q && resp1_ready_i) resp1_valid_d = 1'b0;
      if (s1_valid_q && !s1_port_q) begin
         resp0_valid_d  = 1'b1;
         resp0_result_d = alu_result_i;
      end
      if (s1_valid_q && s1_port_q) begin
         resp1_valid_d  = 1'b1;
         resp1_result_d = alu_result_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q     <= 1'b0;
         s1_port_q      <= 1'b0;
         s1_op_q        <= 4'd0;
         s1_a_q         <= '0;
         s1_b_q         <= '0;
         resp0_valid_q  <= 1'b0;
         resp0_result_q <= '0;
         resp1_valid_q  <= 1'b0;
         resp1_result_q <= '0;
         last_grant_q   <= 1'b1;
      end else begin
         s1_valid_q     <= s1_valid_d;
         s1_port_q      <= s1_port_d;
         s1_op_q        <= s1_op_d;
         s1_a_q         <= s1_a_d;
         s1_b_q         <= s1_b_d;
         resp0_valid_q  <= resp0_valid_d;
         resp0_result_q <= resp0_result_d;
         resp1_valid_q  <= resp1_valid_d;
         resp1_result_q <= resp1_result_d;
         last_grant_q   <= last_grant_d;
      end
   end

   assign req0_ready_o   = rdy0;
   assign req1_ready_o   = rdy1;
   assign alu_op_o       = s1_op_q;
   assign alu_a_o        = s1_a_q;
   assign alu_b_o        = s1_b_q;
   assign resp0_valid_o  = resp0_valid_q;
   assign resp0_result_o = resp0_result_q;
   assign resp1_valid_o  = resp1_valid_q;
   assign resp1_result_o = resp1_result_q;
   assign busy_o         = s1_valid_q | resp0_valid_q | resp1_valid_q;

endmodule

// File: tb/tb_uriscv_alu_arb.sv
// Directed bench for uriscv_alu_arb: a round-robin and a fixed-priority instance share the
// request stimulus, each with its own behavioural ALU on the shared-ALU port.
module tb_uriscv_alu_arb;

   localparam logic [3:0] OP_SHIFTL = 4'h1;
   localparam logic [3:0] OP_SHIFTR = 4'h2;
   localparam logic [3:0] OP_SRA    = 4'h3;
   localparam logic [3:0] OP_ADD    = 4'h4;
   localparam logic [3:0] OP_SUB    = 4'h6;
   localparam logic [3:0] OP_AND    = 4'h7;
   localparam logic [3:0] OP_OR     = 4'h8;
   localparam logic [3:0] OP_XOR    = 4'h9;
   localparam logic [3:0] OP_SLT    = 4'hA;
   localparam logic [3:0] OP_SLTS   = 4'hB;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic [3:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        resp0_ready, resp1_ready;

   logic        rr_req0_ready, rr_req1_ready, rr_resp0_valid, rr_resp1_valid, rr_busy;
   logic [31:0] rr_resp0_result, rr_resp1_result, rr_alu_a, rr_alu_b, rr_alu_result;
   logic [3:0]  rr_alu_op;
   logic        fp_req0_ready, fp_req1_ready, fp_resp0_valid, fp_resp1_valid, fp_busy;
   logic [31:0] fp_resp0_result, fp_resp1_result, fp_alu_a, fp_alu_b, fp_alu_result;
   logic [3:0]  fp_alu_op;

   int checks;
   int errors;

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      case (op)
         OP_SHIFTL: return a << b[4:0];
         OP_SHIFTR: return a >> b[4:0];
         OP_SRA:    return $unsigned($signed(a) >>> b[4:0]);
         OP_ADD:    return a + b;
         OP_SUB:    return a - b;
         OP_AND:    return a & b;
         OP_OR:     return a | b;
         OP_XOR:    return a ^ b;
         OP_SLT:    return {31'd0, (a < b)};
         OP_SLTS:   return {31'd0, ($signed(a) < $signed(b))};
         default:   return 32'd0;
      endcase
   endfunction

   assign rr_alu_result = alu_f(rr_alu_op, rr_alu_a, rr_alu_b);
   assign fp_alu_result = alu_f(fp_alu_op, fp_alu_a, fp_alu_b);

   uriscv_alu_arb #(.PORT0_PRIORITY(1'b0)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_valid_i(req0_valid), .req0_ready_o(rr_req0_ready), .req0_op_i(req0_op),
      .req0_a_i(req0_a), .req0_b_i(req0_b),
      .resp0_valid_o(rr_resp0_valid), .resp0_ready_i(resp0_ready), .resp0_result_o(rr_resp0_result),
      .req1_valid_i(req1_valid), .req1_ready_o(rr_req1_ready), .req1_op_i(req1_op),
      .req1_a_i(req1_a), .req1_b_i(req1_b),
      .resp1_valid_o(rr_resp1_valid), .resp1_ready_i(resp1_ready), .resp1_result_o(rr_resp1_result),
      .alu_op_o(rr_alu_op), .alu_a_o(rr_alu_a), .alu_b_o(rr_alu_b), .alu_result_i(rr_alu_result),
      .busy_o(rr_busy)
   );

   uriscv_alu_arb #(.PORT0_PRIORITY(1'b1)) dut_fp (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_valid_i(req0_valid), .req0_ready_o(fp_req0_ready), .req0_op_i(req0_op),
      .req0_a_i(req0_a), .req0_b_i(req0_b),
      .resp0_valid_o(fp_resp0_valid), .resp0_ready_i(resp0_ready), .resp0_result_o(fp_resp0_result),
      .req1_valid_i(req1_valid), .req1_ready_o(fp_req1_ready), .req1_op_i(req1_op),
      .req1_a_i(req1_a), .req1_b_i(req1_b),
      .resp1_valid_o(fp_resp1_valid), .resp1_ready_i(resp1_ready), .resp1_result_o(fp_resp1_result),
      .alu_op_o(fp_alu_op), .alu_a_o(fp_alu_a), .alu_b_o(fp_alu_b), .alu_result_i(fp_alu_result),
      .busy_o(fp_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic clear_inputs();
      req0_valid = 1'b0; req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
      req1_valid = 1'b0; req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
      resp0_ready = 1'b0; resp1_ready = 1'b0;
   endtask

   // Leaves the caller 1 time unit after a rising edge with reset released.
   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      checks++; if (rr_resp0_valid !== 1'b0) begin errors++; $display("FAIL rst_resp0_valid: got %b want 0", rr_resp0_valid); end
      checks++; if (rr_resp1_valid !== 1'b0) begin errors++; $display("FAIL rst_resp1_valid: got %b want 0", rr_resp1_valid); end
      checks++; if (rr_resp0_result !== 32'd0) begin errors++; $display("FAIL rst_resp0_result: got %h want 0", rr_resp0_result); end
      checks++; if (rr_resp1_result !== 32'd0) begin errors++; $display("FAIL rst_resp1_result: got %h want 0", rr_resp1_result); end
      checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", rr_busy); end
      checks++; if (fp_busy !== 1'b0) begin errors++; $display("FAIL rst_fp_busy: got %b want 0", fp_busy); end
      checks++; if (rr_alu_op !== 4'd0) begin errors++; $display("FAIL rst_alu_op: got %h want 0", rr_alu_op); end
      checks++; if (rr_alu_a !== 32'd0 || rr_alu_b !== 32'd0) begin errors++; $display("FAIL rst_alu_ab: got %h/%h want 0/0", rr_alu_a, rr_alu_b); end
      checks++; if (rr_req0_ready !== 1'b1) begin errors++; $display("FAIL rst_req0_ready: got %b want 1", rr_req0_ready); end
      checks++; if (rr_req1_ready !== 1'b1) begin errors++; $display("FAIL rst_req1_ready: got %b want 1", rr_req1_ready); end
   endtask

   task automatic test_single_add();
      do_reset();
      resp0_ready = 1'b1;
      req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'h5; req0_b = 32'h3;
      @(negedge clk);
      checks++; if (rr_req0_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b want 1", rr_req0_ready); end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(negedge clk);
      checks++; if (rr_alu_op !== OP_ADD || rr_alu_a !== 32'h5 || rr_alu_b !== 32'h3) begin errors++; $display("FAIL add_issue: got op %h a %h b %h want 4/5/3", rr_alu_op, rr_alu_a, rr_alu_b); end
      checks++; if (rr_resp0_valid !== 1'b0 || rr_busy !== 1'b1) begin errors++; $display("FAIL add_s1_state: got resp_valid %b busy %b want 0/1", rr_resp0_valid, rr_busy); end
      checks++; if (rr_req0_ready !== 1'b0) begin errors++; $display("FAIL add_inflight_ready: got %b want 0", rr_req0_ready); end
      @(negedge clk);
      checks++; if (rr_resp0_valid !== 1'b1) begin errors++; $display("FAIL add_resp_valid: got %b want 1", rr_resp0_valid); end
      checks++; if (rr_resp0_result !== 32'h8) begin errors++; $display("FAIL add_result: got %h want 00000008", rr_resp0_result); end
      @(negedge clk);
      checks++; if (rr_resp0_valid !== 1'b0 || rr_busy !== 1'b0) begin errors++; $display("FAIL add_drain: got resp_valid %b busy %b want 0/0", rr_resp0_valid, rr_busy); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      req0_valid = 1'b1; req0_op = OP_SUB; req0_a = 32'd10; req0_b = 32'd4;
      req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 32'hF0F0F0F0; req1_b = 32'hFFFFFFFF;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++; if (rr_req0_ready !== (i % 2 == 0) || rr_req1_ready !== (i % 2 == 1)) begin errors++; $display("FAIL b2b_grant[%0d]: got r0 %b r1 %b want %b %b", i, rr_req0_ready, rr_req1_ready, (i % 2 == 0), (i % 2 == 1)); end
         if (i >= 2 && i % 2 == 0) begin
            checks++; if (rr_resp0_valid !== 1'b1 || rr_resp0_result !== 32'h00000006) begin errors++; $display("FAIL b2b_sub[%0d]: got v %b r %h want 1 00000006", i, rr_resp0_valid, rr_resp0_result); end
         end
         if (i >= 3 && i % 2 == 1) begin
            checks++; if (rr_resp1_valid !== 1'b1 || rr_resp1_result !== 32'h0F0F0F0F) begin errors++; $display("FAIL b2b_xor[%0d]: got v %b r %h want 1 0f0f0f0f", i, rr_resp1_valid, rr_resp1_result); end
         end
      end
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic test_priority();
      do_reset();
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd1;
      req1_op = OP_ADD; req1_a = 32'd1; req1_b = 32'd1;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(posedge clk); #1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      checks++; if (rr_req0_ready !== 1'b0 || rr_req1_ready !== 1'b1) begin errors++; $display("FAIL rr_tie_after_p0: got r0 %b r1 %b want 0 1", rr_req0_ready, rr_req1_ready); end
      checks++; if (fp_req0_ready !== 1'b1 || fp_req1_ready !== 1'b0) begin errors++; $display("FAIL fp_tie: got r0 %b r1 %b want 1 0", fp_req0_ready, fp_req1_ready); end
      checks++; if (fp_resp0_valid !== 1'b1 || fp_resp0_result !== 32'd2) begin errors++; $display("FAIL fp_first_result: got v %b r %h want 1 00000002", fp_resp0_valid, fp_resp0_result); end
      for (int i = 1; i < 6; i++) begin
         @(negedge clk);
         checks++; if (fp_req0_ready !== (i % 2 == 0) || fp_req1_ready !== (i % 2 == 1)) begin errors++; $display("FAIL fp_stream[%0d]: got r0 %b r1 %b want %b %b", i, fp_req0_ready, fp_req1_ready, (i % 2 == 0), (i % 2 == 1)); end
      end
      checks++; if (fp_resp1_valid !== 1'b1 || fp_resp1_result !== 32'd2) begin errors++; $display("FAIL fp_p1_result: got v %b r %h want 1 00000002", fp_resp1_valid, fp_resp1_result); end
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic test_backpressure();
      do_reset();
      resp0_ready = 1'b1; resp1_ready = 1'b0;
      req1_valid = 1'b1; req1_op = OP_SLTS; req1_a = 32'hFFFFFFFF; req1_b = 32'd1;
      @(negedge clk);
      checks++; if (rr_req1_ready !== 1'b1) begin errors++; $display("FAIL bp_p1_first_ready: got %b want 1", rr_req1_ready); end
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd2; req0_b = 32'd3;
      @(negedge clk);
      checks++; if (rr_req1_ready !== 1'b0 || rr_req0_ready !== 1'b1) begin errors++; $display("FAIL bp_p0_proceeds: got r0 %b r1 %b want 1 0", rr_req0_ready, rr_req1_ready); end
      for (int i = 2; i <= 6; i++) begin
         @(negedge clk);
         checks++; if (rr_resp1_valid !== 1'b1 || rr_resp1_result !== 32'd1) begin errors++; $display("FAIL bp_hold[%0d]: got v %b r %h want 1 00000001", i, rr_resp1_valid, rr_resp1_result); end
         checks++; if (rr_req1_ready !== 1'b0) begin errors++; $display("FAIL bp_p1_blocked[%0d]: got %b want 0", i, rr_req1_ready); end
         if (i == 3 || i == 5) begin
            checks++; if (rr_resp0_valid !== 1'b1 || rr_resp0_result !== 32'd5) begin errors++; $display("FAIL bp_p0_result[%0d]: got v %b r %h want 1 00000005", i, rr_resp0_valid, rr_resp0_result); end
         end
      end
      @(posedge clk); #1;
      resp1_ready = 1'b1;
      @(negedge clk);
      checks++; if (rr_req1_ready !== 1'b1 || rr_resp1_valid !== 1'b1) begin errors++; $display("FAIL bp_release: got r1 %b resp1_v %b want 1 1", rr_req1_ready, rr_resp1_valid); end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      checks++; if (rr_resp1_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", rr_resp1_valid); end
      @(negedge clk);
      checks++; if (rr_resp1_valid !== 1'b1 || rr_resp1_result !== 32'd1) begin errors++; $display("FAIL bp_reissue: got v %b r %h want 1 00000001", rr_resp1_valid, rr_resp1_result); end
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic test_reset_midop();
      do_reset();
      resp0_ready = 1'b0; resp1_ready = 1'b1;
      req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd5; req0_b = 32'd3;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 32'd1; req1_b = 32'd2;
      @(posedge clk); #1;
      req1_valid = 1'b0;
      #1;
      checks++; if (rr_busy !== 1'b1 || rr_resp0_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got busy %b resp0_v %b want 1 1", rr_busy, rr_resp0_valid); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (rr_resp0_valid !== 1'b0 || rr_resp1_valid !== 1'b0 || rr_busy !== 1'b0) begin errors++; $display("FAIL mid_valids: got r0v %b r1v %b busy %b want 0 0 0", rr_resp0_valid, rr_resp1_valid, rr_busy); end
      checks++; if (rr_resp0_result !== 32'd0 || rr_alu_a !== 32'd0 || rr_alu_op !== 4'd0) begin errors++; $display("FAIL mid_data: got r0 %h a %h op %h want 0 0 0", rr_resp0_result, rr_alu_a, rr_alu_op); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      checks++; if (rr_req0_ready !== 1'b1 || rr_req1_ready !== 1'b0) begin errors++; $display("FAIL mid_tie: got r0 %b r1 %b want 1 0", rr_req0_ready, rr_req1_ready); end
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      checks++; if (rr_alu_op !== OP_ADD || rr_alu_a !== 32'd5) begin errors++; $display("FAIL mid_winner: got op %h a %h want 4 00000005", rr_alu_op, rr_alu_a); end
   endtask

   task automatic test_shift();
      do_reset();
      resp1_ready = 1'b1;
      req1_valid = 1'b1; req1_op = OP_SRA; req1_a = 32'h80000000; req1_b = 32'd4;
      @(posedge clk); #1;
      req1_valid = 1'b0;
      @(negedge clk);
      checks++; if (rr_alu_op !== OP_SRA || rr_alu_a !== 32'h80000000 || rr_alu_b !== 32'd4) begin errors++; $display("FAIL sra_passthru: got op %h a %h b %h want 3 80000000 4", rr_alu_op, rr_alu_a, rr_alu_b); end
      @(negedge clk);
      checks++; if (rr_resp1_valid !== 1'b1 || rr_resp1_result !== 32'hF8000000) begin errors++; $display("FAIL sra_result: got v %b r %h want 1 f8000000", rr_resp1_valid, rr_resp1_result); end
      @(negedge clk);
      checks++; if (rr_resp1_valid !== 1'b0 || rr_busy !== 1'b0) begin errors++; $display("FAIL sra_drain: got v %b busy %b want 0 0", rr_resp1_valid, rr_busy); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single_add();
      test_back_to_back();
      test_priority();
      test_backpressure();
      test_reset_midop();
      test_shift();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
